// File: rtl/jt49_env_ctrl.sv
// Envelope sequencer: decodes R11-R13, runs the prescaler and the 16-bit period
// counter, and gates envelope steps through an IDLE/RUN/HELD cycle tracker.
module jt49_env_ctrl #(
  parameter int PRESC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic       step,
  output logic       null_period,
  output logic       restart,
  output logic [3:0] ctrl,
  output logic       cycle_done,
  output logic       env_active
);

  typedef enum logic [1:0] {IDLE, RUN, HELD} state_t;

  localparam logic [7:0] PRESC_LAST = 8'(PRESC - 1);

  state_t      state;
  logic [15:0] period;
  logic [15:0] cnt;
  logic [7:0]  presc;
  logic [4:0]  step_cnt;
  logic        tick;
  logic        expiry;
  logic        wr_shape;
  logic        hold;

  assign tick       = cen && (presc == PRESC_LAST);
  // 17-bit compare so a period of 0xFFFF never wraps; periods 0 and 1 expire every tick
  assign expiry     = tick && (({1'b0, cnt} + 17'd1) >= {1'b0, period});
  assign wr_shape   = wr && (addr == 4'd13);
  assign hold       = !ctrl[3] || ctrl[0];
  assign env_active = (state == RUN);

  // period registers ignore cen, so a tick on the write clk still sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= 16'd0;
    end else if (wr) begin
      case (addr)
        4'd11:   period[7:0]  <= din;
        4'd12:   period[15:8] <= din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      null_period <= 1'b0;
    end else if (cen) begin
      null_period <= (period == 16'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restart    <= 1'b0;
      ctrl       <= 4'd0;
      presc      <= 8'd0;
      cnt        <= 16'd0;
      step_cnt   <= 5'd0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
      state      <= IDLE;
    end else begin
      restart <= wr_shape;
      if (wr_shape) begin
        // a shape write overrides any coincident tick/expiry
        ctrl       <= din[3:0];
        presc      <= 8'd0;
        cnt        <= 16'd0;
        step_cnt   <= 5'd0;
        step       <= 1'b0;
        cycle_done <= 1'b0;
        state      <= RUN;
      end else if (cen) begin
        presc      <= tick ? 8'd0 : presc + 8'd1;
        if (tick) cnt <= expiry ? 16'd0 : cnt + 16'd1;
        step       <= expiry && (state == RUN);
        cycle_done <= expiry && (state == RUN) && (step_cnt == 5'd31);
        if (expiry && state == RUN) begin
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == 5'd31 && hold) state <= HELD;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt49_env_ctrl.sv
// Directed bench for jt49_env_ctrl (PRESC=8, cen held high except where noted).
module tb_jt49_env_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       wr = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] din = 8'd0;
  logic       step, null_period, restart, cycle_done, env_active;
  logic [3:0] ctrl;

  int n_chk = 0;
  int n_err = 0;

  // per-run statistics, filled by run()
  int steps, dones, done_at, first, gap_err, act_lo, rst_hi;

  jt49_env_ctrl #(.PRESC(8)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .step(step), .null_period(null_period), .restart(restart), .ctrl(ctrl),
    .cycle_done(cycle_done), .env_active(env_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // clock n edges, sampling 1 time unit after each; index k counts from 1
  task automatic run(input int n, input int gap);
    int last;
    last = -1; steps = 0; dones = 0; done_at = -1; first = -1;
    gap_err = 0; act_lo = 0; rst_hi = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (step) begin
        steps++;
        if (first < 0) first = k;
        else if (k - last != gap) gap_err++;
        last = k;
      end
      if (cycle_done) begin dones++; done_at = k; end
      if (!env_active) act_lo++;
      if (restart) rst_hi++;
    end
  endtask

  initial begin
    // reset state and IDLE suppression
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step", step, 0);
    chk("rst_restart", restart, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_active", env_active, 0);
    @(negedge clk) rst = 1'b0;
    run(20, 8);
    chk("idle_steps", steps, 0);
    chk("idle_null", null_period, 1);

    // period 3, continuous alternate shape
    wr_reg(4'd11, 8'd3);
    wr_reg(4'd12, 8'd0);
    wr_reg(4'd13, 8'h0E);
    chk("t1_restart", restart, 1);
    chk("t1_ctrl", ctrl, 4'hE);
    chk("t1_active", env_active, 1);
    run(800, 24);
    chk("t1_restart_width", rst_hi, 0);
    chk("t1_first", first, 24);
    chk("t1_steps", steps, 33);
    chk("t1_gap", gap_err, 0);
    chk("t1_dones", dones, 1);
    chk("t1_done_at", done_at, 768);
    chk("t1_active_lo", act_lo, 0);

    // period 1, CONT+HOLD: holds after 32 steps
    wr_reg(4'd11, 8'd1);
    wr_reg(4'd13, 8'h09);
    run(1300, 8);
    chk("t2_first", first, 8);
    chk("t2_steps", steps, 32);
    chk("t2_gap", gap_err, 0);
    chk("t2_dones", dones, 1);
    chk("t2_done_at", done_at, 256);
    chk("t2_active", env_active, 0);
    chk("t2_ctrl", ctrl, 4'h9);

    // period 0
    wr_reg(4'd11, 8'd0);
    chk("t3_null_old", null_period, 0);
    @(posedge clk); #1;
    chk("t3_null_new", null_period, 1);
    wr_reg(4'd13, 8'h0E);
    run(100, 8);
    chk("t3_first", first, 8);
    chk("t3_steps", steps, 12);
    chk("t3_gap", gap_err, 0);

    // shrink period 0x100 -> 0x010 while cnt is 0x80
    wr_reg(4'd12, 8'd1);
    wr_reg(4'd13, 8'h0E);
    run(1030, 0);
    chk("t4_no_steps", steps, 0);
    wr_reg(4'd11, 8'h10);
    wr_reg(4'd12, 8'h00);  // coincides with a tick that must see 0x0110
    chk("t4_null", null_period, 0);
    run(300, 128);
    chk("t4_first", first, 8);
    chk("t4_steps", steps, 3);
    chk("t4_gap", gap_err, 0);

    // shape write on the exact cen of an expiry
    run(91, 128);
    chk("t5_pre_steps", steps, 0);
    wr_reg(4'd13, 8'h0E);
    chk("t5_step", step, 0);
    chk("t5_restart", restart, 1);
    run(200, 128);
    chk("t5_first", first, 128);
    chk("t5_steps", steps, 1);

    // async reset while step is high
    run(56, 128);
    chk("t6_step_pre", step, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_step", step, 0);
    chk("t6_restart", restart, 0);
    chk("t6_ctrl", ctrl, 0);
    chk("t6_done", cycle_done, 0);
    chk("t6_active", env_active, 0);
    chk("t6_null", null_period, 0);
    @(negedge clk) rst = 1'b0;
    run(100, 8);
    chk("t6_idle_steps", steps, 0);
    chk("t6_idle_null", null_period, 1);

    // restart is decoded regardless of cen
    cen = 1'b0;
    wr_reg(4'd13, 8'h09);
    chk("t7_restart", restart, 1);
    chk("t7_ctrl", ctrl, 4'h9);
    cen = 1'b1;
    run(20, 8);
    chk("t7_first", first, 8);
    chk("t7_steps", steps, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
